return_stack_unit: RTL

- Hardware return-address stack for the Gumnut core. It supplies the stack address that the next-PC logic selects on ret/reti.
- Pushes a return address plus Z/C flags on jsb or interrupt entry. Pops on ret/reti.
- Sits between the control unit (push/pop strobes), the datapath flag register (flags in/out) and the next-PC mux (stack address out).

---
 rtl/gumnut_pkg.sv | 15 +
 rtl/return_stack_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/gumnut_pkg.sv
`default_nettype none
// gumnut_pkg: shared types and sizes for the Gumnut core's control-flow units.
package gumnut_pkg;

   localparam int STACK_DEPTH = 8;
   localparam int ADDR_W      = 12;

   typedef struct packed {
      logic              zero;
      logic              carry;
      logic [ADDR_W-1:0] addr;
   } stack_entry_t;

endpackage
`default_nettype wire

// File: rtl/return_stack_unit.sv
`default_nettype none
// return_stack_unit: return-address stack holding {Z, C, addr} for jsb/interrupt entry,
// popped on ret/reti; top entry is presented combinationally to the next-PC mux.
module return_stack_unit
   import gumnut_pkg::*;
#(
   parameter int DEPTH = STACK_DEPTH,
   parameter int AW    = ADDR_W
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [AW-1:0]            push_addr_i,
   input  logic                     zero_i,
   input  logic                     carry_i,
   input  logic                     clr_err_i,
   output logic [AW-1:0]            stack_addr_o,
   output logic                     zero_o,
   output logic                     carry_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   depth_o,
   output logic                     overflow_o,
   output logic                     underflow_o
);

   localparam int IW  = $clog2(DEPTH);
   localparam int SPW = IW + 1;
   localparam int EW  = AW + 2;
   localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
   localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
   localparam logic [IW-1:0]  IDX_ONE  = IW'(1);

   logic [SPW-1:0] sp_q, sp_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;
   logic [EW-1:0]  mem_q [DEPTH];
   logic [EW-1:0]  mem_d [DEPTH];

   logic           empty, full;
   logic [IW-1:0]  top_idx;
   logic [EW-1:0]  top_entry;
   logic [EW-1:0]  wr_entry;

   assign empty     = (sp_q == '0);
   assign full      = (sp_q == SP_FULL);
   // DEPTH is a power of two, so sp==DEPTH truncates to 0 and 0-1 lands on DEPTH-1.
   assign top_idx   = sp_q[IW-1:0] - IDX_ONE;
   assign top_entry = empty ? '0 : mem_q[top_idx];
   assign wr_entry  = {zero_i, carry_i, push_addr_i};

   always_comb begin
      sp_d  = sp_q;
      ovf_d = clr_err_i ? 1'b0 : ovf_q;
      unf_d = clr_err_i ? 1'b0 : unf_q;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end

      if (push_i && (!pop_i || empty)) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            mem_d[sp_q[IW-1:0]] = wr_entry;
            sp_d                = sp_q + SP_ONE;
         end
      end else if (push_i && pop_i) begin
         // Replace the top in place: a ret immediately followed by a jsb.
         mem_d[top_idx] = wr_entry;
      end else if (pop_i) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            sp_d = sp_q - SP_ONE;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   assign stack_addr_o = top_entry[AW-1:0];
   assign carry_o      = top_entry[AW];
   assign zero_o       = top_entry[AW+1];
   assign empty_o      = empty;
   assign full_o       = full;
   assign depth_o      = sp_q;
   assign overflow_o   = ovf_q;
   assign underflow_o  = unf_q;

endmodule
`default_nettype wire
